// File: rtl/bin_to_bcd_converter.sv
// Sequential double-dabble binary to 4-digit BCD converter, one bit per clock.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits with 4'hF.
module bin_to_bcd_converter #(
    parameter int unsigned BIN_WIDTH = 14
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic [BIN_WIDTH-1:0] bin_i,
    output logic [3:0]           thousands_o,
    output logic [3:0]           hundreds_o,
    output logic [3:0]           tens_o,
    output logic [3:0]           units_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 overflow_o
);

    localparam int unsigned WW = BIN_WIDTH + 16;
    localparam int unsigned CW = $clog2(BIN_WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LATCH = 2'd2
    } state_e;

    state_e          state_q;
    logic [WW-1:0]   work_q;
    logic [WW-1:0]   work_adj;
    logic [WW-1:0]   work_d;
    logic [CW-1:0]   cnt_q;
    logic            ovf_flag_q;
    logic [15:0]     digits_q;
    logic [15:0]     bcd_d;
    logic            busy_q;
    logic            done_q;
    logic            overflow_q;
    logic            ovf_in;

    function automatic logic [3:0] add3(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    always_comb begin
        work_adj = work_q;
        for (int k = 0; k < 4; k++) begin
            work_adj[BIN_WIDTH + 4*k +: 4] = add3(work_q[BIN_WIDTH + 4*k +: 4]);
        end
        work_d = work_adj << 1;
    end

    // Values above 9999 only fit when bin_i has 14 bits; narrower widths fold to 0.
    assign ovf_in = (32'(bin_i) > 32'd9999);

`ifdef LEADING_ZERO_BLANK_EN
    function automatic logic [15:0] blank_lz(input logic [15:0] d);
        logic [15:0] r;
        r = d;
        if (r[15:12] == 4'h0) begin
            r[15:12] = 4'hF;
            if (r[11:8] == 4'h0) begin
                r[11:8] = 4'hF;
                if (r[7:4] == 4'h0) begin
                    r[7:4] = 4'hF;
                end
            end
        end
        return r;
    endfunction

    assign bcd_d = blank_lz(work_q[WW-1 -: 16]);
`else
    assign bcd_d = work_q[WW-1 -: 16];
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            work_q     <= '0;
            cnt_q      <= '0;
            ovf_flag_q <= 1'b0;
            digits_q   <= 16'h0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            busy_q <= (state_q != IDLE);
            unique case (state_q)
                IDLE: begin
                    if (start_i) begin
                        work_q     <= {16'h0, bin_i};
                        cnt_q      <= CW'(BIN_WIDTH);
                        ovf_flag_q <= ovf_in;
                        state_q    <= SHIFT;
                    end
                end
                SHIFT: begin
                    work_q <= work_d;
                    cnt_q  <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_q <= LATCH;
                    end
                end
                LATCH: begin
                    digits_q   <= ovf_flag_q ? 16'h9999 : bcd_d;
                    overflow_q <= ovf_flag_q;
                    done_q     <= 1'b1;
                    state_q    <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign thousands_o = digits_q[15:12];
    assign hundreds_o  = digits_q[11:8];
    assign tens_o      = digits_q[7:4];
    assign units_o     = digits_q[3:0];
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign overflow_o  = overflow_q;

endmodule

// File: tb/tb_bin_to_bcd_converter.sv
// Directed testbench for bin_to_bcd_converter.
// Expected digits follow LEADING_ZERO_BLANK_EN when it is defined.
module tb_bin_to_bcd_converter;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [13:0] bin;
    logic [3:0]  th, hu, te, un;
    logic        busy, done, ovf;

    int n_tests = 0;
    int n_fail  = 0;

    bin_to_bcd_converter #(.BIN_WIDTH(14)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .start_i     (start),
        .bin_i       (bin),
        .thousands_o (th),
        .hundreds_o  (hu),
        .tens_o      (te),
        .units_o     (un),
        .busy_o      (busy),
        .done_o      (done),
        .overflow_o  (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] digs();
        return {th, hu, te, un};
    endfunction

    // Start one conversion; report edges to done and busy-high sample count.
    task automatic run_conv(input logic [13:0] v, output int lat,
                            output int nbusy);
        bin   = v;
        start = 1'b1;
        tick();
        start = 1'b0;
        lat   = 40;
        nbusy = 0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (busy) nbusy++;
            if (done) begin
                lat = k;
                break;
            end
        end
    endtask

    int lat, nb, ndone, first_d, second_d, bad_b, bad_d, bad_g;
    logic [15:0] d1, d2;

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        bin   = '0;
        tick();
        tick();
        chk("reset_digits", 32'(digs()), 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_done", 32'(done), 32'h0);
        chk("reset_ovf", 32'(ovf), 32'h0);
        rst_n = 1'b1;
        tick();

        run_conv(14'd1234, lat, nb);
        chk("basic_latency", 32'(lat), 32'd15);
        chk("basic_busy_cycles", 32'(nb), 32'd15);
        chk("basic_digits", 32'(digs()), 32'h1234);
        chk("basic_ovf", 32'(ovf), 32'h0);
        tick();
        chk("basic_busy_low", 32'(busy), 32'h0);
        chk("basic_done_low", 32'(done), 32'h0);

        // Abort mid-shift with an asynchronous reset.
        bin   = 14'd1234;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_digits", 32'(digs()), 32'h0);
        chk("rst_async_busy", 32'(busy), 32'h0);
        tick();
        #2 rst_n = 1'b1;
        ndone = 0;
        for (int k = 0; k < 25; k++) begin
            tick();
            if (done) ndone++;
        end
        chk("rst_no_done", 32'(ndone), 32'd0);
        run_conv(14'd1234, lat, nb);
        chk("rst_recover_latency", 32'(lat), 32'd15);
        chk("rst_recover_digits", 32'(digs()), 32'h1234);
        tick();

        run_conv(14'd0, lat, nb);
`ifdef LEADING_ZERO_BLANK_EN
        chk("zero_digits", 32'(digs()), 32'hFFF0);
`else
        chk("zero_digits", 32'(digs()), 32'h0000);
`endif
        chk("zero_ovf", 32'(ovf), 32'h0);
        tick();
        run_conv(14'd9999, lat, nb);
        chk("max_digits", 32'(digs()), 32'h9999);
        chk("max_ovf", 32'(ovf), 32'h0);
        tick();
        run_conv(14'd10000, lat, nb);
        chk("sat_digits", 32'(digs()), 32'h9999);
        chk("sat_ovf", 32'(ovf), 32'h1);
        tick();
        run_conv(14'd16383, lat, nb);
        chk("sat_top_digits", 32'(digs()), 32'h9999);
        tick();
        run_conv(14'd7, lat, nb);
        chk("ovf_cleared", 32'(ovf), 32'h0);
        tick();

        // A start while busy is dropped.
        bin   = 14'd42;
        start = 1'b1;
        tick();
        start = 1'b0;
        ndone = 0;
        for (int k = 1; k <= 40; k++) begin
            if (k == 4) begin
                start = 1'b1;
                bin   = 14'd777;
            end
            if (k == 5) start = 1'b0;
            tick();
            if (done) ndone++;
        end
        chk("busy_start_dones", 32'(ndone), 32'd1);
`ifdef LEADING_ZERO_BLANK_EN
        chk("busy_start_digits", 32'(digs()), 32'hFF42);
`else
        chk("busy_start_digits", 32'(digs()), 32'h0042);
`endif

        // Back-to-back with start held high.
        bin      = 14'd305;
        start    = 1'b1;
        first_d  = 0;
        second_d = 0;
        bad_g    = 0;
        d1       = '0;
        d2       = '0;
        tick();
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (k == 16) start = 1'b0;
            if (done) begin
                if (first_d == 0) begin
                    first_d = k;
                    d1      = digs();
                    bin     = 14'd8191;
                end else if (second_d == 0) begin
                    second_d = k;
                    d2       = digs();
                end
            end else if (first_d != 0 && second_d == 0 && digs() != d1) begin
                bad_g++;
            end
        end
        start = 1'b0;
        chk("b2b_first_edge", 32'(first_d), 32'd15);
        chk("b2b_gap", 32'(second_d - first_d), 32'd16);
`ifdef LEADING_ZERO_BLANK_EN
        chk("b2b_digits_a", 32'(d1), 32'hF305);
`else
        chk("b2b_digits_a", 32'(d1), 32'h0305);
`endif
        chk("b2b_digits_b", 32'(d2), 32'h8191);
        chk("b2b_stable", 32'(bad_g), 32'd0);
        tick();

        // Outputs hold while idle and bin_i wanders.
        run_conv(14'd5060, lat, nb);
        chk("hold_conv", 32'(digs()), 32'h5060);
        bad_g = 0;
        bad_b = 0;
        bad_d = 0;
        tick();
        for (int k = 0; k < 100; k++) begin
            bin = 14'($urandom);
            tick();
            if (digs() != 16'h5060) bad_g++;
            if (busy) bad_b++;
            if (done) bad_d++;
        end
        chk("hold_digits", 32'(bad_g), 32'd0);
        chk("hold_busy", 32'(bad_b), 32'd0);
        chk("hold_done", 32'(bad_d), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
